// File: rtl/cpu_run_monitor_if.sv
// Core-side observation bundle for the run monitor: executed PC and data-memory store port.
interface cpu_run_monitor_if #(
    parameter int XLEN = 32
);
    logic            pc_valid_i;
    logic [XLEN-1:0] pc_i;
    logic            dmem_we_i;
    logic [XLEN-1:0] dmem_addr_i;
    logic [XLEN-1:0] dmem_wdata_i;

    modport master (
        output pc_valid_i, pc_i, dmem_we_i, dmem_addr_i, dmem_wdata_i
    );

    modport slave (
        input pc_valid_i, pc_i, dmem_we_i, dmem_addr_i, dmem_wdata_i
    );
endinterface

// File: rtl/cpu_run_monitor.sv
// Run controller and end-of-test monitor: sequences core reset, counts cycles/instret,
// and latches the first end condition (halt, tohost pass/fail, self-loop, timeout).
module cpu_run_monitor #(
    parameter int          XLEN         = 32,
    parameter int          CNT_W        = 32,
    parameter int          RESET_CYCLES = 4,
    parameter logic [31:0] HALT_ADDR    = 32'h80000078,
    parameter logic [31:0] TOHOST_ADDR  = 32'h80001000,
    parameter int          MAX_CYCLES   = 100000,
    parameter int          LOOP_LIMIT   = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  clear_i,
    cpu_run_monitor_if.slave      core,
    output logic                  cpu_rstn_o,
    output logic                  running_o,
    output logic                  done_o,
    output logic [2:0]            status_o,
    output logic [XLEN-1:0]       exit_code_o,
    output logic [CNT_W-1:0]      cycle_cnt_o,
    output logic [CNT_W-1:0]      instret_o
);
    typedef enum logic [1:0] {HOLD, RUN, DONE} state_t;

    localparam logic [31:0]     HOLD_LAST = 32'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOOP_LIM = CNT_W'(LOOP_LIMIT);
    localparam logic [CNT_W-1:0] MAX_CYC  = CNT_W'(MAX_CYCLES);
    localparam logic [2:0] ST_NONE = 3'd0, ST_HALT = 3'd1, ST_PASS = 3'd2,
                           ST_FAIL = 3'd3, ST_TIMEOUT = 3'd4, ST_LOOP = 3'd5;

    state_t           state, state_n;
    logic [31:0]      hold_cnt, hold_n;
    logic [CNT_W-1:0] loop_cnt, loop_n;
    logic [XLEN-1:0]  last_pc, last_pc_n;
    logic             cpu_rstn_n;
    logic [2:0]       status_n;
    logic [XLEN-1:0]  exit_n;
    logic [CNT_W-1:0] cycle_n, instret_n;
    logic             pc_same, tohost_hit;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    assign running_o = (state == RUN);
    assign done_o    = (state == DONE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= HOLD;
            hold_cnt    <= '0;
            loop_cnt    <= '0;
            last_pc     <= '1;
            cpu_rstn_o  <= 1'b0;
            status_o    <= ST_NONE;
            exit_code_o <= '0;
            cycle_cnt_o <= '0;
            instret_o   <= '0;
        end else begin
            state       <= state_n;
            hold_cnt    <= hold_n;
            loop_cnt    <= loop_n;
            last_pc     <= last_pc_n;
            cpu_rstn_o  <= cpu_rstn_n;
            status_o    <= status_n;
            exit_code_o <= exit_n;
            cycle_cnt_o <= cycle_n;
            instret_o   <= instret_n;
        end
    end

    always_comb begin
        state_n    = state;
        hold_n     = hold_cnt;
        loop_n     = loop_cnt;
        last_pc_n  = last_pc;
        cpu_rstn_n = cpu_rstn_o;
        status_n   = status_o;
        exit_n     = exit_code_o;
        cycle_n    = cycle_cnt_o;
        instret_n  = instret_o;
        pc_same    = core.pc_valid_i && (core.pc_i == last_pc);
        tohost_hit = core.dmem_we_i && (core.dmem_addr_i == XLEN'(TOHOST_ADDR))
                     && core.dmem_wdata_i[0];

        if (clear_i) begin
            state_n    = HOLD;
            hold_n     = '0;
            loop_n     = '0;
            last_pc_n  = '1;
            cpu_rstn_n = 1'b0;
            status_n   = ST_NONE;
            exit_n     = '0;
            cycle_n    = '0;
            instret_n  = '0;
        end else begin
            case (state)
                HOLD: begin
                    hold_n = hold_cnt + 32'd1;
                    if (hold_cnt == HOLD_LAST) begin
                        state_n    = RUN;
                        hold_n     = '0;
                        cpu_rstn_n = 1'b1;
                    end
                end
                RUN: begin
                    cycle_n = sat_inc(cycle_cnt_o);
                    if (core.pc_valid_i && !pc_same) begin
                        instret_n = sat_inc(instret_o);
                        loop_n    = '0;
                        last_pc_n = core.pc_i;
                    end else if (pc_same) begin
                        loop_n = sat_inc(loop_cnt);
                    end
                    // Events use the updated counts so the event cycle itself is counted.
                    if (tohost_hit) begin
                        if (core.dmem_wdata_i == XLEN'(1)) begin
                            status_n = ST_PASS;
                        end else begin
                            status_n = ST_FAIL;
                            exit_n   = core.dmem_wdata_i >> 1;
                        end
                        state_n = DONE;
                    end else if (core.pc_valid_i && core.pc_i == XLEN'(HALT_ADDR)) begin
                        status_n = ST_HALT;
                        state_n  = DONE;
                    end else if (LOOP_LIMIT != 0 && pc_same && loop_n == LOOP_LIM) begin
                        status_n = ST_LOOP;
                        state_n  = DONE;
                    end else if (MAX_CYCLES != 0 && cycle_n == MAX_CYC) begin
                        status_n = ST_TIMEOUT;
                        state_n  = DONE;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_run_monitor.sv
// Self-checking bench for cpu_run_monitor: directed test-plan scenarios plus randomized runs
// compared cycle-by-cycle against an event-level reference model.
module tb_cpu_run_monitor;
    localparam int          XLEN         = 32;
    localparam int          CNT_W        = 32;
    localparam int          RESET_CYCLES = 4;
    localparam int          LOOP_LIMIT   = 16;
    localparam int          MAX_CYCLES   = 50;
    localparam logic [31:0] HALT_ADDR    = 32'h80000078;
    localparam logic [31:0] TOHOST_ADDR  = 32'h80001000;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             clear_i = 1'b0;
    logic             cpu_rstn_o, running_o, done_o;
    logic [2:0]       status_o;
    logic [XLEN-1:0]  exit_code_o;
    logic [CNT_W-1:0] cycle_cnt_o, instret_o;

    int n_checks = 0;
    int n_pass   = 0;

    cpu_run_monitor_if #(.XLEN(XLEN)) bus ();

    cpu_run_monitor #(
        .XLEN(XLEN), .CNT_W(CNT_W), .RESET_CYCLES(RESET_CYCLES),
        .HALT_ADDR(HALT_ADDR), .TOHOST_ADDR(TOHOST_ADDR),
        .MAX_CYCLES(MAX_CYCLES), .LOOP_LIMIT(LOOP_LIMIT)
    ) dut (
        .clk(clk), .rstn(rstn), .clear_i(clear_i), .core(bus),
        .cpu_rstn_o(cpu_rstn_o), .running_o(running_o), .done_o(done_o),
        .status_o(status_o), .exit_code_o(exit_code_o),
        .cycle_cnt_o(cycle_cnt_o), .instret_o(instret_o)
    );

    always #5 clk = ~clk;

    // Reference model: phase flags, edge counts and the last retired PC.
    bit          m_run, m_done, m_cpu_rstn;
    int          m_hold, m_status;
    int unsigned m_cyc, m_inst, m_rep;
    logic [31:0] m_last, m_exit;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic model_reset();
        m_run = 0; m_done = 0; m_cpu_rstn = 0; m_hold = 0; m_status = 0;
        m_cyc = 0; m_inst = 0; m_rep = 0; m_last = '1; m_exit = 0;
    endtask

    task automatic model_edge();
        bit v, same;
        logic [31:0] pc, wd;
        v    = bus.pc_valid_i;
        pc   = bus.pc_i;
        wd   = bus.dmem_wdata_i;
        same = v && (pc == m_last);
        if (clear_i) begin
            model_reset();
        end else if (m_done) begin
        end else if (!m_run) begin
            m_hold++;
            if (m_hold == RESET_CYCLES) begin
                m_run = 1;
                m_cpu_rstn = 1;
            end
        end else begin
            m_cyc++;
            if (v && !same) begin
                m_inst++;
                m_last = pc;
                m_rep = 0;
            end else if (same) begin
                m_rep++;
            end
            if (bus.dmem_we_i && bus.dmem_addr_i == TOHOST_ADDR && wd[0]) begin
                if (wd == 32'd1) m_status = 2;
                else begin
                    m_status = 3;
                    m_exit = wd / 2;
                end
            end else if (v && pc == HALT_ADDR) m_status = 1;
            else if (LOOP_LIMIT != 0 && same && m_rep == LOOP_LIMIT) m_status = 5;
            else if (MAX_CYCLES != 0 && m_cyc == MAX_CYCLES) m_status = 4;
            if (m_status != 0) begin
                m_run = 0;
                m_done = 1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".cpu_rstn"}, 64'(cpu_rstn_o), 64'(m_cpu_rstn));
        check({tag, ".running"},  64'(running_o),  64'(m_run));
        check({tag, ".done"},     64'(done_o),     64'(m_done));
        check({tag, ".status"},   64'(status_o),   64'(m_status));
        check({tag, ".exit"},     64'(exit_code_o), 64'(m_exit));
        check({tag, ".cycles"},   64'(cycle_cnt_o), 64'(m_cyc));
        check({tag, ".instret"},  64'(instret_o),  64'(m_inst));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        if (rstn) model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic drive(input bit v, input logic [31:0] pc, input bit we,
                         input logic [31:0] addr, input logic [31:0] wd);
        bus.pc_valid_i   = v;
        bus.pc_i         = pc;
        bus.dmem_we_i    = we;
        bus.dmem_addr_i  = addr;
        bus.dmem_wdata_i = wd;
    endtask

    task automatic restart();
        drive(0, '0, 0, '0, '0);
        clear_i = 1'b1;
        step("clear");
        clear_i = 1'b0;
        repeat (RESET_CYCLES) step("hold");
    endtask

    task automatic halt_run();
        for (int i = 0; i <= 30; i++) begin
            drive(1, 32'h80000000 + 32'(4 * i), 0, '0, '0);
            step("halt");
        end
        check("halt_done", 64'(done_o), 64'd1);
        check("halt_status", 64'(status_o), 64'd1);
        check("halt_instret", 64'(instret_o), 64'd31);
        check("halt_cycles", 64'(cycle_cnt_o), 64'd31);
    endtask

    initial begin
        drive(0, '0, 0, '0, '0);
        model_reset();
        #1;
        check_all("por");
        repeat (2) step("rst_low");
        rstn = 1'b1;
        for (int i = 1; i <= RESET_CYCLES; i++) begin
            step("release");
            if (i < RESET_CYCLES) check("cpu_rstn_held", 64'(cpu_rstn_o), 64'd0);
        end
        check("cpu_rstn_up", 64'(cpu_rstn_o), 64'd1);
        check("running_up", 64'(running_o), 64'd1);
        check("cycles_zero", 64'(cycle_cnt_o), 64'd0);

        halt_run();
        // Inputs in DONE must not disturb the latched result.
        drive(1, 32'h80000010, 1, TOHOST_ADDR, 32'd7);
        repeat (3) step("done_sticky");
        check("sticky_status", 64'(status_o), 64'd1);

        restart();
        drive(0, '0, 1, TOHOST_ADDR, 32'd1);
        step("pass");
        check("pass_status", 64'(status_o), 64'd2);

        restart();
        drive(0, '0, 1, TOHOST_ADDR, 32'd7);
        step("fail");
        check("fail_status", 64'(status_o), 64'd3);
        check("fail_exit", 64'(exit_code_o), 64'd3);

        restart();
        drive(0, '0, 1, TOHOST_ADDR, 32'd6);
        step("even_store");
        check("even_ignored", 64'(done_o), 64'd0);
        drive(1, HALT_ADDR, 1, TOHOST_ADDR, 32'd1);
        step("prio");
        check("prio_status", 64'(status_o), 64'd2);

        restart();
        drive(1, 32'h80000010, 0, '0, '0);
        repeat (LOOP_LIMIT) step("loop");
        check("loop_early", 64'(done_o), 64'd0);
        step("loop");
        check("loop_status", 64'(status_o), 64'd5);
        check("loop_instret", 64'(instret_o), 64'd1);

        restart();
        for (int i = 0; i < MAX_CYCLES; i++) begin
            drive(1, 32'h100 + 32'(4 * i), 0, '0, '0);
            step("tmo");
            if (i == MAX_CYCLES - 2) check("tmo_early", 64'(done_o), 64'd0);
        end
        check("tmo_status", 64'(status_o), 64'd4);
        check("tmo_cycles", 64'(cycle_cnt_o), 64'd50);

        restart();
        for (int i = 0; i < 5; i++) begin
            drive(1, 32'h80000000 + 32'(4 * i), 0, '0, '0);
            step("pre_async");
        end
        #3;
        rstn = 1'b0;
        model_reset();
        #1;
        check_all("async");
        check("async_cycles", 64'(cycle_cnt_o), 64'd0);
        check("async_cpu_rstn", 64'(cpu_rstn_o), 64'd0);
        #1;
        rstn = 1'b1;
        drive(0, '0, 0, '0, '0);
        repeat (RESET_CYCLES) step("rehold");
        halt_run();
        restart();
        halt_run();

        for (int r = 0; r < 25; r++) begin
            int npc, len;
            logic [31:0] pc;
            restart();
            npc = $urandom_range(1, 4);
            len = $urandom_range(10, 70);
            for (int c = 0; c < len; c++) begin
                pc = 32'h80000000 + 32'(4 * ($urandom % npc));
                if ($urandom % 16 == 0) pc = HALT_ADDR;
                drive(($urandom % 4) != 0, pc, ($urandom % 10) == 0,
                      ($urandom % 2) ? TOHOST_ADDR : 32'h80000ff0, 32'($urandom % 8));
                clear_i = ($urandom % 50) == 0;
                step("rnd");
            end
            clear_i = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
